// File: rtl/eth_send.sv
// -----------------------------------------------------------------------------
// eth_send -- Ethernet transmit framer (byte stream toward the PHY)
//
// A single accepted start request builds one complete frame:
//   preamble/SFD, MAC header, ARP request/reply body or IPv4+UDP headers with
//   payload pulled from a show-ahead FIFO, zero padding to the 60-byte minimum,
//   FCS, then an inter-frame gap. pkt_type encoding matches eth_recv.
//
// Optional feature (macro ETH_SEND_IP_ID_EN):
//   defined   -> IPv4 ID is a 16-bit counter bumped after every UDP frame
//   undefined -> IPv4 ID is always 16'h0000
//
// Ports:
//   clk, rst_n          byte clock, asynchronous active-low reset
//   i_start             start request (taken only when o_busy=0, type!=0)
//   i_pkt_type          0=NONE 1=ARP_REQ 2=ARP_RESP 3=UDP
//   i_self_mac/ip       source MAC/IP (also ARP SHA/SPA)
//   i_dst_mac/ip        destination MAC/IP (also ARP THA/TPA)
//   i_src_port/dst_port UDP ports
//   i_pay_len           UDP payload length (clamped to MAX_PAYLOAD)
//   o_pay_rd            FIFO pop, i_pay_data consumed in the same cycle
//   i_pay_data          FIFO head byte
//   o_data, o_data_vl   registered byte stream to the PHY
//   o_busy              frame or IFG in progress
//   o_done              one-cycle pulse alongside the last FCS byte
// -----------------------------------------------------------------------------
module eth_send #(
  parameter int          IFG_BYTES   = 12,
  parameter logic [7:0]  IP_TTL      = 8'd64,
  parameter logic [10:0] MAX_PAYLOAD = 11'd1472
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [1:0]  i_pkt_type,
  input  logic [47:0] i_self_mac,
  input  logic [31:0] i_self_ip,
  input  logic [47:0] i_dst_mac,
  input  logic [31:0] i_dst_ip,
  input  logic [15:0] i_src_port,
  input  logic [15:0] i_dst_port,
  input  logic [10:0] i_pay_len,
  output logic        o_pay_rd,
  input  logic [7:0]  i_pay_data,
  output logic [7:0]  o_data,
  output logic        o_data_vl,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_PREAMBLE, S_ETH_HDR, S_ARP_BODY, S_IP_HDR,
    S_UDP_HDR, S_PAYLOAD, S_PAD, S_FCS, S_IFG
  } state_t;

  localparam logic [1:0] PKT_ARP_REQ = 2'd1;
  localparam logic [1:0] PKT_UDP     = 2'd3;

  // Reflected CRC-32, one byte per call (LSB of the byte enters first).
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      x = x[0] ? ((x >> 1) ^ 32'hEDB8_8320) : (x >> 1);
    end
    return x;
  endfunction

  // r_state/r_cnt describe the byte currently on o_data; w_nstate/w_ncnt the
  // byte being loaded into the output register at the next edge.
  state_t       r_state, w_nstate;
  logic [10:0]  r_cnt,   w_ncnt;

  logic [1:0]   r_type;
  logic [47:0]  r_self_mac, r_dst_mac;
  logic [31:0]  r_self_ip,  r_dst_ip;
  logic [15:0]  r_src_port, r_dst_port;
  logic [10:0]  r_pay_len;
  logic [15:0]  r_csum;
  logic [31:0]  r_crc;
  logic [7:0]   r_data;
  logic         r_data_vl;
  logic         r_done;

  logic         w_accept;
  logic         w_is_arp, w_is_req;
  logic [10:0]  w_pad_len;
  state_t       w_after_body;
  logic [15:0]  w_ip_id, w_ip_len, w_udp_len, w_csum;
  logic [47:0]  w_eth_dst, w_tha;
  logic [19:0]  w_sum, w_fold1, w_fold2;
  logic [223:0] w_vec, w_shift;
  logic         w_use_vec;
  logic [7:0]   w_byte;
  logic         w_vl_n, w_done_n, w_crc_en;
  logic [31:0]  w_fcs;

  assign w_accept  = i_start && (r_state == S_IDLE) && (i_pkt_type != 2'd0);
  assign w_is_arp  = (r_type != PKT_UDP);
  assign w_is_req  = (r_type == PKT_ARP_REQ);
  assign w_eth_dst = w_is_req ? 48'hFFFF_FFFF_FFFF : r_dst_mac;
  assign w_tha     = w_is_req ? 48'h0 : r_dst_mac;
  assign w_ip_len  = 16'd28 + {5'd0, r_pay_len};
  assign w_udp_len = 16'd8  + {5'd0, r_pay_len};
  assign w_fcs     = ~r_crc;

  // Bytes from dst MAC to end of body: ARP 42, UDP 42+len; pad up to 60.
  assign w_pad_len    = w_is_arp ? 11'd18 :
                        (r_pay_len < 11'd18) ? (11'd18 - r_pay_len) : 11'd0;
  assign w_after_body = (w_pad_len != 11'd0) ? S_PAD : S_FCS;

`ifdef ETH_SEND_IP_ID_EN
  logic [15:0] r_ip_id;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_ip_id <= 16'h0000;
    else if (r_done && r_type == PKT_UDP) r_ip_id <= r_ip_id + 16'd1;
  end
  assign w_ip_id = r_ip_id;
`else
  assign w_ip_id = 16'h0000;
`endif

  // Header checksum over the nine non-checksum words; the 20-bit sum folds
  // to 16 bits in at most two carry-add steps.
  assign w_sum   = 20'h04500 + {4'h0, w_ip_len} + {4'h0, w_ip_id} + 20'h04000 +
                   {4'h0, IP_TTL, 8'h11} +
                   {4'h0, r_self_ip[31:16]} + {4'h0, r_self_ip[15:0]} +
                   {4'h0, r_dst_ip[31:16]}  + {4'h0, r_dst_ip[15:0]};
  assign w_fold1 = {4'h0, w_sum[15:0]}   + {16'h0, w_sum[19:16]};
  assign w_fold2 = {4'h0, w_fold1[15:0]} + {16'h0, w_fold1[19:16]};
  assign w_csum  = ~w_fold2[15:0];

  // ---------------------------------------------------------------- state reg
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 11'd0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
    end
  end

  // --------------------------------------------------------------- next state
  // NOTE: defaults assigned first so no path through the case leaves a
  // combinational output unassigned (which would infer a latch).
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt + 11'd1;
    unique case (r_state)
      S_IDLE: begin
        w_ncnt = 11'd0;
        if (w_accept) w_nstate = S_PREAMBLE;
      end
      S_PREAMBLE: if (r_cnt == 11'd7) begin
        w_nstate = S_ETH_HDR;
        w_ncnt   = 11'd0;
      end
      S_ETH_HDR: if (r_cnt == 11'd13) begin
        w_nstate = w_is_arp ? S_ARP_BODY : S_IP_HDR;
        w_ncnt   = 11'd0;
      end
      S_ARP_BODY: if (r_cnt == 11'd27) begin
        w_nstate = w_after_body;
        w_ncnt   = 11'd0;
      end
      S_IP_HDR: if (r_cnt == 11'd19) begin
        w_nstate = S_UDP_HDR;
        w_ncnt   = 11'd0;
      end
      S_UDP_HDR: if (r_cnt == 11'd7) begin
        w_nstate = (r_pay_len != 11'd0) ? S_PAYLOAD : w_after_body;
        w_ncnt   = 11'd0;
      end
      S_PAYLOAD: if (r_cnt == r_pay_len - 11'd1) begin
        w_nstate = w_after_body;
        w_ncnt   = 11'd0;
      end
      S_PAD: if (r_cnt == w_pad_len - 11'd1) begin
        w_nstate = S_FCS;
        w_ncnt   = 11'd0;
      end
      S_FCS: if (r_cnt == 11'd3) begin
        w_nstate = S_IFG;
        w_ncnt   = 11'd0;
      end
      S_IFG: if (r_cnt == 11'(IFG_BYTES - 1)) begin
        w_nstate = S_IDLE;
        w_ncnt   = 11'd0;
      end
      default: begin
        w_nstate = S_IDLE;
        w_ncnt   = 11'd0;
      end
    endcase
  end

  // ------------------------------------------------------------------ outputs
  // Selects the byte for the next output position. Header fields are packed
  // MSB-first into a left-aligned vector and the byte index picks the top.
  always_comb begin
    w_vec     = '0;
    w_use_vec = 1'b0;
    w_byte    = 8'h00;
    unique case (w_nstate)
      S_PREAMBLE: w_byte = (w_ncnt == 11'd7) ? 8'hD5 : 8'h55;
      S_ETH_HDR: begin
        w_vec     = {w_eth_dst, r_self_mac, 8'h08, (w_is_arp ? 8'h06 : 8'h00), 112'h0};
        w_use_vec = 1'b1;
      end
      S_ARP_BODY: begin
        w_vec     = {16'h0001, 16'h0800, 8'h06, 8'h04, 8'h00, (w_is_req ? 8'h01 : 8'h02),
                     r_self_mac, r_self_ip, w_tha, r_dst_ip};
        w_use_vec = 1'b1;
      end
      S_IP_HDR: begin
        w_vec     = {16'h4500, w_ip_len, w_ip_id, 16'h4000, IP_TTL, 8'h11, r_csum,
                     r_self_ip, r_dst_ip, 64'h0};
        w_use_vec = 1'b1;
      end
      S_UDP_HDR: begin
        w_vec     = {r_src_port, r_dst_port, w_udp_len, 16'h0000, 160'h0};
        w_use_vec = 1'b1;
      end
      S_PAYLOAD: w_byte = i_pay_data;
      S_FCS: begin
        // ~crc goes out least-significant byte first
        unique case (w_ncnt[1:0])
          2'd0:    w_byte = w_fcs[7:0];
          2'd1:    w_byte = w_fcs[15:8];
          2'd2:    w_byte = w_fcs[23:16];
          default: w_byte = w_fcs[31:24];
        endcase
      end
      default: w_byte = 8'h00;
    endcase
    w_shift = w_vec << {w_ncnt[4:0], 3'b000};
    if (w_use_vec) w_byte = w_shift[223:216];

    w_vl_n   = (w_nstate != S_IDLE) && (w_nstate != S_IFG);
    w_done_n = (w_nstate == S_FCS) && (w_ncnt == 11'd3);
    w_crc_en = w_nstate inside {S_ETH_HDR, S_ARP_BODY, S_IP_HDR, S_UDP_HDR, S_PAYLOAD, S_PAD};
    o_pay_rd = (w_nstate == S_PAYLOAD);
    o_busy   = (r_state != S_IDLE);
  end

  // ----------------------------------------------------------------- datapath
  // NOTE: the latched request fields are reset along with the control state;
  // there is no storage array here, so a full reset costs nothing extra.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_type     <= 2'd0;
      r_self_mac <= 48'h0;
      r_dst_mac  <= 48'h0;
      r_self_ip  <= 32'h0;
      r_dst_ip   <= 32'h0;
      r_src_port <= 16'h0;
      r_dst_port <= 16'h0;
      r_pay_len  <= 11'd0;
      r_csum     <= 16'h0;
      r_crc      <= 32'hFFFF_FFFF;
      r_data     <= 8'h00;
      r_data_vl  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_type     <= i_pkt_type;
        r_self_mac <= i_self_mac;
        r_dst_mac  <= i_dst_mac;
        r_self_ip  <= i_self_ip;
        r_dst_ip   <= i_dst_ip;
        r_src_port <= i_src_port;
        r_dst_port <= i_dst_port;
        r_pay_len  <= (i_pay_len > MAX_PAYLOAD) ? MAX_PAYLOAD : i_pay_len;
        r_crc      <= 32'hFFFF_FFFF;
      end else if (w_crc_en) begin
        r_crc <= crc32_byte(r_crc, w_byte);
      end
      // Recomputed every cycle from latched fields; settles the cycle after
      // accept, long before the IP header is reached.
      r_csum    <= w_csum;
      r_data    <= w_byte;
      r_data_vl <= w_vl_n;
      r_done    <= w_done_n;
    end
  end

  assign o_data    = r_data;
  assign o_data_vl = r_data_vl;
  assign o_done    = r_done;

endmodule

// File: tb/tb_eth_send.sv
// -----------------------------------------------------------------------------
// tb_eth_send -- directed self-checking bench for eth_send
// Frames are captured byte-wise from o_data while o_data_vl is high and
// compared against hand-computed field values and a byte-list frame model.
// -----------------------------------------------------------------------------
module tb_eth_send;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [1:0]  i_pkt_type;
  logic [47:0] i_self_mac, i_dst_mac;
  logic [31:0] i_self_ip, i_dst_ip;
  logic [15:0] i_src_port, i_dst_port;
  logic [10:0] i_pay_len;
  logic        o_pay_rd;
  logic [7:0]  i_pay_data;
  logic [7:0]  o_data;
  logic        o_data_vl, o_busy, o_done;

  eth_send dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_pkt_type (i_pkt_type),
    .i_self_mac (i_self_mac),
    .i_self_ip  (i_self_ip),
    .i_dst_mac  (i_dst_mac),
    .i_dst_ip   (i_dst_ip),
    .i_src_port (i_src_port),
    .i_dst_port (i_dst_port),
    .i_pay_len  (i_pay_len),
    .o_pay_rd   (o_pay_rd),
    .i_pay_data (i_pay_data),
    .o_data     (o_data),
    .o_data_vl  (o_data_vl),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model: head advances on each clocked pop.
  logic [7:0] pay_mem [2048];
  int         pidx = 0;
  int         pay_base = 0;
  assign i_pay_data = pay_mem[(pidx - pay_base) & 2047];
  always @(posedge clk) if (o_pay_rd) pidx <= pidx + 1;

  // Capture monitor.
  logic [7:0] cap [$];
  int         done_total = 0;
  int         done_idx   = 0;
  int         rd_total   = 0;
  always @(negedge clk) begin
    if (o_data_vl) cap.push_back(o_data);
    if (o_done) begin
      done_total <= done_total + 1;
      done_idx   <= cap.size();
    end
    if (o_pay_rd) rd_total <= rd_total + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  logic [7:0] fr [$];
  logic [7:0] exp_q [$];
  logic [15:0] exp_id = 16'h0000;
  int cap_base, rd_base, done_base;

  function automatic logic [127:0] fbytes(input int off, input int n);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = (r << 8) | ((off + i < fr.size()) ? 128'(fr[off + i]) : 128'h0);
    return r;
  endfunction

  task automatic push_bytes(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
  endtask

  task automatic build_expected(input logic [1:0] t, input logic [10:0] len_raw, input logic [15:0] id);
    int len;
    logic [15:0] w [10];
    logic [31:0] s, crc;
    len = (len_raw > 11'd1472) ? 1472 : int'(len_raw);
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    push_bytes((t == 2'd1) ? 64'hFFFF_FFFF_FFFF : 64'(i_dst_mac), 6);
    push_bytes(64'(i_self_mac), 6);
    push_bytes((t == 2'd3) ? 64'h0800 : 64'h0806, 2);
    if (t != 2'd3) begin
      push_bytes(64'h0001_0800_0604, 6);
      push_bytes((t == 2'd1) ? 64'h1 : 64'h2, 2);
      push_bytes(64'(i_self_mac), 6);
      push_bytes(64'(i_self_ip), 4);
      push_bytes((t == 2'd1) ? 64'h0 : 64'(i_dst_mac), 6);
      push_bytes(64'(i_dst_ip), 4);
    end else begin
      w[0] = 16'h4500; w[1] = 16'(28 + len); w[2] = id; w[3] = 16'h4000;
      w[4] = 16'h4011; w[5] = 16'h0000;
      w[6] = i_self_ip[31:16]; w[7] = i_self_ip[15:0];
      w[8] = i_dst_ip[31:16];  w[9] = i_dst_ip[15:0];
      s = 0;
      for (int i = 0; i < 10; i++) s += 32'(w[i]);
      while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
      w[5] = ~s[15:0];
      for (int i = 0; i < 10; i++) push_bytes(64'(w[i]), 2);
      push_bytes(64'(i_src_port), 2);
      push_bytes(64'(i_dst_port), 2);
      push_bytes(64'(8 + len), 2);
      push_bytes(64'h0, 2);
      for (int i = 0; i < len; i++) exp_q.push_back(pay_mem[i]);
    end
    while (exp_q.size() - 8 < 60) exp_q.push_back(8'h00);
    crc = 32'hFFFF_FFFF;
    for (int i = 8; i < exp_q.size(); i++) crc = crc_upd(crc, exp_q[i]);
    crc = ~crc;
    for (int i = 0; i < 4; i++) exp_q.push_back(crc[8*i +: 8]);
  endtask

  // Launch one frame and wait (bounded) for the IFG to end.
  task automatic send(input string tag, input logic [1:0] t, input logic [10:0] len);
    int n;
    @(negedge clk);
    cap_base  = cap.size();
    rd_base   = rd_total;
    done_base = done_total;
    pay_base  = pidx;
    i_pkt_type = t;
    i_pay_len  = len;
    i_start    = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check({tag, "_first_byte"}, {o_busy, o_data_vl, o_data}, {1'b1, 1'b1, 8'h55});
    n = 0;
    while (o_busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_timeout"}, 128'(n < 4000), 128'(1));
    fr = cap[cap_base:$];
  endtask

  task automatic verify(input string tag, input logic [1:0] t, input logic [10:0] len);
    int mism, exp_rd;
    logic [31:0] r;
    build_expected(t, len, exp_id);
    check({tag, "_len"}, 128'(fr.size()), 128'(exp_q.size()));
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= fr.size() || fr[i] !== exp_q[i]) mism++;
    check({tag, "_bytes_bad"}, 128'(mism), 128'(0));
    r = 32'hFFFF_FFFF;
    for (int i = 8; i < fr.size(); i++) r = crc_upd(r, fr[i]);
    check({tag, "_crc_residue"}, 128'(r), 128'(32'hDEBB_20E3));
    check({tag, "_done_cnt"}, 128'(done_total - done_base), 128'(1));
    check({tag, "_done_pos"}, 128'(done_idx - cap_base), 128'(exp_q.size()));
    exp_rd = (t != 2'd3) ? 0 : (len > 11'd1472) ? 1472 : int'(len);
    check({tag, "_pay_rd_cnt"}, 128'(rd_total - rd_base), 128'(exp_rd));
`ifdef ETH_SEND_IP_ID_EN
    if (t == 2'd3) exp_id = exp_id + 16'd1;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    exp_id = 16'h0000;
  endtask

  logic        tr_vl [250];
  logic        tr_busy [250];
  logic [7:0]  tr_d [250];

  initial begin
    int nz, n, d0, st_n;
    int starts[$];
    int ends[$];
    logic [15:0] id_exp;
    rst_n = 1'b0; i_start = 1'b0; i_pkt_type = 2'd0; i_pay_len = 11'd0;
    i_self_mac = 48'h0200_0000_0001; i_dst_mac = 48'h0211_2233_4455;
    i_self_ip  = 32'hC0A8_0001;      i_dst_ip  = 32'hC0A8_00C7;
    i_src_port = 16'h1234;           i_dst_port = 16'h5678;
    for (int i = 0; i < 2048; i++) pay_mem[i] = 8'(i * 37 + 11);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {o_data, o_data_vl, o_busy, o_done, o_pay_rd}, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", {o_data, o_data_vl, o_busy, o_done, o_pay_rd}, 128'h0);

    // Type 0 start is ignored
    i_pkt_type = 2'd0; i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    check("type0_ignored", {o_busy, o_data_vl}, 128'h0);

    // Checksum vector
    send("udp87", 2'd3, 11'd87);
    check("udp87_ip_hdr", fbytes(22, 12), 128'h4500_0073_0000_4000_4011_B861);
    check("udp87_vl_cycles", 128'(fr.size()), 128'(141));
    verify("udp87", 2'd3, 11'd87);

    // ARP request
    send("arpreq", 2'd1, 11'd0);
    check("arpreq_vl_cycles", 128'(fr.size()), 128'(72));
    check("arpreq_dst_mac", fbytes(8, 6), 128'hFFFF_FFFF_FFFF);
    check("arpreq_ethtype", fbytes(20, 2), 128'h0806);
    check("arpreq_oper", fbytes(28, 2), 128'h0001);
    check("arpreq_tha", fbytes(40, 6), 128'h0);
    check("arpreq_tpa", fbytes(46, 4), 128'hC0A8_00C7);
    nz = 0;
    for (int i = 50; i < 68; i++) if (i >= fr.size() || fr[i] != 8'h00) nz++;
    check("arpreq_pad_zeros", 128'(nz), 128'(0));
    verify("arpreq", 2'd1, 11'd0);

    // ARP reply
    send("arpresp", 2'd2, 11'd0);
    check("arpresp_oper", fbytes(28, 2), 128'h0002);
    check("arpresp_tha", fbytes(40, 6), 128'h0211_2233_4455);
    verify("arpresp", 2'd2, 11'd0);

    // UDP with zero payload
    send("udp0", 2'd3, 11'd0);
    check("udp0_vl_cycles", 128'(fr.size()), 128'(72));
    check("udp0_ip_total_len", fbytes(24, 2), 128'h001C);
    check("udp0_udp_len", fbytes(46, 2), 128'h0008);
    verify("udp0", 2'd3, 11'd0);

    // Short payload (partial pad), random lengths, clamp
    i_src_port = 16'hABCD; i_dst_port = 16'h0035;
    send("udp5", 2'd3, 11'd5);
    verify("udp5", 2'd3, 11'd5);
    for (int k = 0; k < 2; k++) begin
      n = $urandom_range(1472, 1);
      for (int i = 0; i < 2048; i++) pay_mem[i] = 8'($urandom);
      send("udp_rand", 2'd3, 11'(n));
      verify("udp_rand", 2'd3, 11'(n));
    end
    send("udp_clamp", 2'd3, 11'd2000);
    check("udp_clamp_vl_cycles", 128'(fr.size()), 128'(1526));
    verify("udp_clamp", 2'd3, 11'd2000);

    // Reset mid-payload
    @(negedge clk);
    pay_base = pidx; i_pkt_type = 2'd3; i_pay_len = 11'd100; i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    n = 0;
    while (!o_pay_rd && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reach_payload", 128'(n < 200), 128'(1));
    repeat (10) @(negedge clk);
    d0 = done_total;
    #2 rst_n = 1'b0;
    #1 check("rst_mid_outputs", {o_data_vl, o_busy, o_done, o_pay_rd}, 128'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_id = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_mid_no_done", 128'(done_total - d0), 128'(0));
    send("after_rst", 2'd3, 11'd20);
    verify("after_rst", 2'd3, 11'd20);

    // Back-to-back with i_start held high
    do_reset();
    i_pkt_type = 2'd3; i_pay_len = 11'd4;
    @(negedge clk);
    d0 = done_total;
    i_start = 1'b1;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      tr_vl[i] = o_data_vl; tr_busy[i] = o_busy; tr_d[i] = o_data;
    end
    i_start = 1'b0;
    for (int i = 0; i < 250; i++) begin
      if (tr_vl[i] && (i == 0 || !tr_vl[i-1])) starts.push_back(i);
      if (tr_vl[i] && (i == 249 || !tr_vl[i+1])) ends.push_back(i + 1);
    end
    check("b2b_frame_count", 128'(starts.size()), 128'(3));
    check("b2b_done_count", 128'(done_total - d0), 128'(3));
    st_n = (starts.size() < ends.size()) ? starts.size() : ends.size();
    for (int k = 0; k < st_n; k++) begin
      check("b2b_frame_len", 128'(ends[k] - starts[k]), 128'(72));
`ifdef ETH_SEND_IP_ID_EN
      id_exp = 16'(k);
`else
      id_exp = 16'h0000;
`endif
      if (starts[k] + 27 < 250)
        check("b2b_ip_id", 128'({tr_d[starts[k] + 26], tr_d[starts[k] + 27]}), 128'(id_exp));
      if (k + 1 < starts.size()) begin
        int ifg, idle;
        ifg = 0; idle = 0;
        for (int i = ends[k]; i < starts[k + 1]; i++) begin
          if (tr_busy[i]) ifg++;
          else idle++;
        end
        check("b2b_ifg_busy_cycles", 128'(ifg), 128'(12));
        check("b2b_idle_cycles", 128'(idle), 128'(1));
      end
    end
    n = 0;
    while (o_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b2b_drain", 128'(n < 200), 128'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
